// File: rtl/bist_sequencer.sv
// Programmable memory BIST sequencer: holds a short march program and replays it
// against an external memory-under-test, counting and locating read mismatches.
module bist_sequencer #(
    parameter int DEPTH      = 256,
    parameter int PROG_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       prog_we,
    input  logic [9:0] prog_data,
    input  logic       prog_clr,
    input  logic       start,
    output logic       mut_en,
    output logic       mut_we,
    output logic [7:0] mut_addr,
    output logic [6:0] mut_wdata,
    input  logic [6:0] mut_rdata,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] fail_addr,
    output logic [2:0] fail_step,
    output logic [7:0] err_cnt,
    output logic [3:0] prog_cnt
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WR, RD, CMP, RMW_WR, DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_END = 2'b00,
        OP_W   = 2'b01,
        OP_R   = 2'b10,
        OP_RW  = 2'b11
    } op_e;

    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] prog_cnt_q, prog_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic [7:0] fail_addr_q, fail_addr_d;
    logic [2:0] fail_step_q, fail_step_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       mut_en_q, mut_en_d;
    logic       mut_we_q, mut_we_d;
    logic [7:0] mut_addr_q, mut_addr_d;
    logic [6:0] mut_wdata_q, mut_wdata_d;

    logic [9:0] prog_mem [PROG_DEPTH];
    logic       prog_wr;
    logic       advance;

    logic [9:0] cur_word;
    op_e        cur_op;
    logic       cur_dir;
    logic [6:0] cur_pat;
    logic       at_last;
    logic [7:0] next_addr;

    // Step index wraps the 3-bit memory index; bit 3 only matters for the
    // full-program end test against prog_cnt.
    assign cur_word  = prog_mem[step_q[2:0]];
    assign cur_op    = op_e'(cur_word[9:8]);
    assign cur_dir   = cur_word[7];
    assign cur_pat   = cur_word[6:0];
    assign at_last   = cur_dir ? (mut_addr_q == 8'd0) : (mut_addr_q == LAST_ADDR);
    assign next_addr = cur_dir ? (mut_addr_q - 8'd1) : (mut_addr_q + 8'd1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        step_d      = step_q;
        prog_cnt_d  = prog_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_step_d = fail_step_q;
        err_cnt_d   = err_cnt_q;
        mut_en_d    = 1'b0;
        mut_we_d    = 1'b0;
        mut_addr_d  = mut_addr_q;
        mut_wdata_d = mut_wdata_q;
        prog_wr     = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (prog_clr) begin
                    prog_cnt_d  = 4'd0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = 8'd0;
                    fail_step_d = 3'd0;
                    err_cnt_d   = 8'd0;
                end else if (prog_we) begin
                    if (prog_cnt_q < 4'(PROG_DEPTH)) begin
                        prog_wr    = 1'b1;
                        prog_cnt_d = prog_cnt_q + 4'd1;
                    end
                end else if (start) begin
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = 8'd0;
                    fail_step_d = 3'd0;
                    err_cnt_d   = 8'd0;
                    step_d      = 4'd0;
                    busy_d      = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (step_q == prog_cnt_q || cur_op == OP_END) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    mut_addr_d = cur_dir ? LAST_ADDR : 8'd0;
                    mut_en_d   = 1'b1;
                    if (cur_op == OP_W) begin
                        mut_we_d    = 1'b1;
                        mut_wdata_d = cur_pat;
                        state_d     = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR:     advance = 1'b1;
            RD:     state_d = CMP;
            CMP: begin
                if (mut_rdata != cur_pat) begin
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    if (!fail_q) begin
                        fail_addr_d = mut_addr_q;
                        fail_step_d = step_q[2:0];
                    end
                    fail_d = 1'b1;
                end
                if (cur_op == OP_RW) begin
                    mut_en_d    = 1'b1;
                    mut_we_d    = 1'b1;
                    mut_wdata_d = ~cur_pat;
                    state_d     = RMW_WR;
                end else begin
                    advance = 1'b1;
                end
            end
            RMW_WR: advance = 1'b1;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Shared end-of-address handling for W, R and RW elements.
        if (advance) begin
            if (at_last) begin
                step_d  = step_q + 4'd1;
                state_d = FETCH;
            end else begin
                mut_addr_d = next_addr;
                mut_en_d   = 1'b1;
                if (cur_op == OP_W) begin
                    mut_we_d    = 1'b1;
                    mut_wdata_d = cur_pat;
                    state_d     = WR;
                end else begin
                    state_d = RD;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            prog_cnt_q  <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= 8'd0;
            fail_step_q <= 3'd0;
            err_cnt_q   <= 8'd0;
            mut_en_q    <= 1'b0;
            mut_we_q    <= 1'b0;
            mut_addr_q  <= 8'd0;
            mut_wdata_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            prog_cnt_q  <= prog_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_step_q <= fail_step_d;
            err_cnt_q   <= err_cnt_d;
            mut_en_q    <= mut_en_d;
            mut_we_q    <= mut_we_d;
            mut_addr_q  <= mut_addr_d;
            mut_wdata_q <= mut_wdata_d;
        end
    end

    // NOTE: program storage has no reset; entries are unreachable until written
    // because prog_cnt resets to zero, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (prog_wr) prog_mem[prog_cnt_q[2:0]] <= prog_data;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_step = fail_step_q;
    assign err_cnt   = err_cnt_q;
    assign prog_cnt  = prog_cnt_q;
    assign mut_en    = mut_en_q;
    assign mut_we    = mut_we_q;
    assign mut_addr  = mut_addr_q;
    assign mut_wdata = mut_wdata_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: a 4-word memory model with an optional bit-0 stuck-at
// fault, a table of programs with expected results, and an access scoreboard.
module tb_bist_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we, prog_clr, start;
    logic [9:0] prog_data;
    logic       mut_en, mut_we;
    logic [7:0] mut_addr;
    logic [6:0] mut_wdata;
    logic [6:0] mut_rdata;
    logic       busy, done, fail;
    logic [7:0] fail_addr, err_cnt;
    logic [2:0] fail_step;
    logic [3:0] prog_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bist_sequencer #(.DEPTH(DEPTH), .PROG_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_data(prog_data),
        .prog_clr(prog_clr), .start(start), .mut_en(mut_en), .mut_we(mut_we),
        .mut_addr(mut_addr), .mut_wdata(mut_wdata), .mut_rdata(mut_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_step(fail_step), .err_cnt(err_cnt), .prog_cnt(prog_cnt)
    );

    // Memory-under-test: reads return data the cycle after the strobe.
    logic [6:0] mem [DEPTH];
    logic       stuck_en = 1'b0;
    logic [1:0] stuck_addr = 2'd0;

    always @(posedge clk) begin
        if (mut_en) begin
            if (mut_we)
                mem[mut_addr[1:0]] <= (stuck_en && mut_addr[1:0] == stuck_addr)
                                      ? (mut_wdata & 7'h7E) : mut_wdata;
            else
                mut_rdata <= mem[mut_addr[1:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [6:0] data;
    } acc_t;

    acc_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n && mut_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access: we=%0b addr=%0d", mut_we, mut_addr);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                check("acc_we", 32'(mut_we), 32'(e.we));
                check("acc_addr", 32'(mut_addr), 32'(e.addr));
                if (e.we) check("acc_wdata", 32'(mut_wdata), 32'(e.data));
            end
        end
    end

    function automatic logic [9:0] w(input logic [1:0] op, input logic dir, input logic [6:0] pat);
        return {op, dir, pat};
    endfunction

    function automatic logic [7:0][9:0] pk(input logic [9:0] a, b, c, d);
        logic [7:0][9:0] p;
        p    = '0;
        p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        return p;
    endfunction

    // Reference model of the access stream a program should produce.
    task automatic build_expected(input logic [7:0][9:0] prog, input int n);
        for (int s = 0; s < n; s++) begin
            logic [1:0] op;
            logic       dir;
            logic [6:0] pat;
            op  = prog[s][9:8];
            dir = prog[s][7];
            pat = prog[s][6:0];
            if (op == 2'b00) break;
            for (int k = 0; k < DEPTH; k++) begin
                logic [7:0] a;
                a = dir ? 8'(DEPTH - 1 - k) : 8'(k);
                if (op == 2'b01) exp_q.push_back('{we: 1'b1, addr: a, data: pat});
                else             exp_q.push_back('{we: 1'b0, addr: a, data: 7'd0});
                if (op == 2'b11) exp_q.push_back('{we: 1'b1, addr: a, data: ~pat});
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); prog_clr = 1'b1;
        @(negedge clk); prog_clr = 1'b0;
    endtask

    task automatic load(input logic [9:0] word);
        @(negedge clk); prog_we = 1'b1; prog_data = word;
        @(negedge clk); prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Entered at the negedge right after start was sampled; counts busy cycles.
    task automatic wait_done(output int busy_n);
        int cyc;
        busy_n = 0;
        cyc    = 0;
        while (!done) begin
            if (busy) busy_n++;
            if (cyc > 500) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: no done after %0d cycles", cyc);
                break;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic [7:0][9:0] prog;
        logic [3:0]      n;
        logic            stuck;
        logic [1:0]      saddr;
        logic            e_fail;
        logic [7:0]      e_faddr;
        logic [2:0]      e_fstep;
        logic [7:0]      e_err;
        logic [7:0]      e_busy;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int busy_n;
        logic [7:0][9:0] p1;

        vecs[0] = '{pk(w(1,0,7'h55), w(2,0,7'h55), 10'h0, 10'h0), 4'd3, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 8'd0, 8'd15};
        vecs[1] = '{pk(w(1,0,7'h55), w(2,0,7'h55), 10'h0, 10'h0), 4'd3, 1'b1, 2'd2, 1'b1, 8'd2, 3'd1, 8'd1, 8'd15};
        vecs[2] = '{pk(w(1,0,7'h2A), w(3,1,7'h2A), 10'h0, 10'h0), 4'd3, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 8'd0, 8'd19};
        vecs[3] = '{pk(10'h0, 10'h0, 10'h0, 10'h0),               4'd0, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 8'd0, 8'd1};
        vecs[4] = '{pk(w(1,0,7'h55), w(2,0,7'h55), w(2,1,7'h55), 10'h0), 4'd4, 1'b1, 2'd2, 1'b1, 8'd2, 3'd1, 8'd2, 8'd24};
        vecs[5] = '{pk(w(1,0,7'h2A), w(2,1,7'h2A), 10'h0, 10'h0), 4'd3, 1'b1, 2'd2, 1'b0, 8'd0, 3'd0, 8'd0, 8'd15};
        vecs[6] = '{pk(w(1,0,7'h2B), w(3,0,7'h2B), 10'h0, 10'h0), 4'd3, 1'b1, 2'd0, 1'b1, 8'd0, 3'd1, 8'd1, 8'd19};

        rst_n = 1'b0; prog_we = 1'b0; prog_clr = 1'b0; start = 1'b0; prog_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mut_en", 32'(mut_en), 0);
        check("rst_prog_cnt", 32'(prog_cnt), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            pulse_clr();
            for (int i = 0; i < int'(vecs[v].n); i++) load(vecs[v].prog[i]);
            check($sformatf("v%0d_prog_cnt", v), 32'(prog_cnt), 32'(vecs[v].n));
            stuck_en   = vecs[v].stuck;
            stuck_addr = vecs[v].saddr;
            build_expected(vecs[v].prog, int'(vecs[v].n));
            pulse_start();
            wait_done(busy_n);
            check($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].e_busy));
            check($sformatf("v%0d_done", v), 32'(done), 1);
            check($sformatf("v%0d_fail", v), 32'(fail), 32'(vecs[v].e_fail));
            check($sformatf("v%0d_fail_addr", v), 32'(fail_addr), 32'(vecs[v].e_faddr));
            check($sformatf("v%0d_fail_step", v), 32'(fail_step), 32'(vecs[v].e_fstep));
            check($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].e_err));
            check($sformatf("v%0d_accesses_left", v), 32'(exp_q.size()), 0);
        end

        // prog_clr clears the sticky results of the last faulty run.
        pulse_clr();
        check("clr_fail", 32'(fail), 0);
        check("clr_err", 32'(err_cnt), 0);
        check("clr_done", 32'(done), 0);

        // Empty program: done exactly two edges after start is sampled.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("empty_busy", 32'(busy), 1);
        check("empty_done_early", 32'(done), 0);
        @(negedge clk);
        check("empty_done", 32'(done), 1);
        check("empty_busy_off", 32'(busy), 0);
        @(negedge clk);
        check("done_held", 32'(done), 1);

        // prog_we with start in IDLE: word stored, start ignored.
        @(negedge clk); prog_we = 1'b1; start = 1'b1; prog_data = w(1,0,7'h11);
        @(negedge clk); prog_we = 1'b0; start = 1'b0;
        check("we_start_cnt", 32'(prog_cnt), 1);
        check("we_start_busy", 32'(busy), 0);

        // Nine writes: ninth (a read element) dropped; eight W steps run.
        pulse_clr();
        p1 = '0;
        for (int i = 0; i < 8; i++) begin
            p1[i] = w(1, 1'(i & 1), 7'(i * 9 + 3));
            load(p1[i]);
        end
        load(w(2,0,7'h40));
        check("nine_prog_cnt", 32'(prog_cnt), 8);
        stuck_en = 1'b0;
        build_expected(p1, 8);
        pulse_start();
        wait_done(busy_n);
        check("nine_busy_cycles", 32'(busy_n), 41);
        check("nine_fail", 32'(fail), 0);
        check("nine_left", 32'(exp_q.size()), 0);

        // Controls while busy are ignored; the result of a faulty run survives.
        pulse_clr();
        p1 = pk(w(1,0,7'h55), w(2,0,7'h55), 10'h0, 10'h0);
        for (int i = 0; i < 3; i++) load(p1[i]);
        stuck_en = 1'b1; stuck_addr = 2'd2;
        build_expected(p1, 3);
        pulse_start();
        @(negedge clk); prog_clr = 1'b1;
        @(negedge clk); prog_clr = 1'b0; prog_we = 1'b1; prog_data = w(2,1,7'h01);
        @(negedge clk); prog_we = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(busy_n);
        check("busy_ign_prog_cnt", 32'(prog_cnt), 3);
        check("busy_ign_fail", 32'(fail), 1);
        check("busy_ign_err", 32'(err_cnt), 1);

        // Rerun without reload.
        build_expected(p1, 3);
        pulse_start();
        wait_done(busy_n);
        check("rerun_busy_cycles", 32'(busy_n), 15);
        check("rerun_err", 32'(err_cnt), 1);
        check("rerun_fail_addr", 32'(fail_addr), 2);

        // Reset during a read strobe.
        build_expected(p1, 3);
        pulse_start();
        for (int c = 0; c < 100 && !(mut_en && !mut_we); c++) @(negedge clk);
        check("rd_seen", 32'(mut_en && !mut_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {mut_en, mut_we, busy, done, fail, mut_addr, mut_wdata},
              32'd0);
        check("midrst_results", {fail_addr, fail_step, err_cnt, prog_cnt}, 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        pulse_start();
        wait_done(busy_n);
        check("post_rst_busy", 32'(busy_n), 1);
        check("post_rst_done", 32'(done), 1);
        check("post_rst_fail", 32'(fail), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameter: DEPTH, 256, number of words in memory-under-test (MUT), 2..256; address width fixed at 8.
REQ-002 Parameter: PROG_DEPTH, 8, number of program words held; step index width 3.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 prog_we  in  1  one-cycle pulse, append prog_data to program (driven by UPDATE_DR under GETTEST).
REQ-006 prog_data  in  10  program word: [9:8] op (00 END, 01 W, 10 R, 11 RW), [7] dir (0 up, 1 down), [6:0] pattern.
REQ-007 prog_clr  in  1  one-cycle pulse, empty program and clear results.
REQ-008 start  in  1  one-cycle pulse, run loaded program (RUNBIST).
REQ-009 mut_en / mut_we  out  1/1  MUT access strobe / write enable.
REQ-010 mut_addr  out  8  MUT address; mut_wdata  out  7  write data; mut_rdata  in  7  read data, valid the cycle after a read strobe.
REQ-011 busy  out  1; done  out  1; fail  out  1; fail_addr  out  8; fail_step  out  3; err_cnt  out  8; prog_cnt  out  4.

Function
REQ-012 States: IDLE, FETCH, WR, RD, CMP, RMW_WR, DONE.
REQ-013 IDLE: prog_we with prog_cnt<PROG_DEPTH stores word at index prog_cnt, prog_cnt+1; prog_we at prog_cnt=PROG_DEPTH ignored.
REQ-014 IDLE: prog_clr sets prog_cnt=0, done=0, fail=0, fail_addr=0, fail_step=0, err_cnt=0.
REQ-015 IDLE: start clears done/fail/fail_addr/fail_step/err_cnt, step=0, goes FETCH next cycle; busy=1 from FETCH until DONE.
REQ-016 Simultaneous prog_we and start in IDLE: word stored, start ignored; prog_clr with start: clear taken, start ignored.
REQ-017 prog_we, prog_clr, start while busy: ignored.
REQ-018 FETCH (1 cycle): step=prog_cnt or op=END -> DONE; else load addr (0 if dir=0, DEPTH-1 if dir=1) and go WR (op W) or RD (op R/RW).
REQ-019 WR: mut_en=1, mut_we=1, mut_wdata=pattern (W) or ~pattern (RW, via RMW_WR); 1 cycle per address.
REQ-020 RD: mut_en=1, mut_we=0, 1 cycle; CMP: compare mut_rdata to pattern, 1 cycle; RW then RMW_WR (write ~pattern) 1 cycle.
REQ-021 Per-address cost: W 1, R 2, RW 3 cycles; after last address (DEPTH-1 up, 0 down) step+1, go FETCH.
REQ-022 mut_en=0 in IDLE, FETCH, CMP, DONE.
REQ-023 Mismatch in CMP: err_cnt+1 saturating at 255; fail=1 sticky; fail_addr/fail_step captured on first mismatch only.
REQ-024 Mismatch does not abort; program runs to completion.
REQ-025 DONE (1 cycle): busy=0, done=1; return IDLE; done held until next start or prog_clr.
REQ-026 Empty program: start -> FETCH -> DONE, fail=0, no MUT access.
REQ-027 Program memory retained across runs; rerun without reload permitted.

Reset
REQ-028 rst_n low: immediately state=IDLE, prog_cnt=0, busy=0, done=0, fail=0, fail_addr=0, fail_step=0, err_cnt=0, mut_en=0, mut_we=0, mut_addr=0, mut_wdata=0, including mid-run.
REQ-029 Program storage contents need not reset; unreachable while prog_cnt=0.

Verification
REQ-030 DEPTH=4, fault-free MUT model; load {01,0,0x55},{10,0,0x55},END; start -> busy 15 cycles, done=1, fail=0, err_cnt=0, writes to addr 0,1,2,3 with 0x55.
REQ-031 Same program, MUT bit 0 stuck-at-0 at addr 2 -> fail=1, fail_addr=2, fail_step=1, err_cnt=1.
REQ-032 Load {11,1,0x2A} (RW down) after W 0x2A; fault-free -> addresses 3,2,1,0 read 0x2A then written 0x55, fail=0.
REQ-033 Nine prog_we pulses -> prog_cnt=8, ninth word dropped; start runs 8 steps then DONE without END.
REQ-034 start with prog_cnt=0 -> done=1 two cycles later, mut_en never asserted.
REQ-035 rst_n low mid-RD -> all outputs zero immediately; after release start with prog_cnt=0 completes as empty program.
